// File: rtl/cdce_link_pkg.sv
// Shared definitions for the CDCE link arbiter and related shared-bus controllers.
// Holds the arbiter state encoding, the default word width and a constant clog2 helper.
package cdce_link_pkg;

   localparam int unsigned DefaultDataWidth = 32;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StGap
   } link_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cdce_link_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr_i, wrapping.
// Shared by the CDCE link arbiter and other shared-bus controllers.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] eligible_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   // Walk from the farthest candidate back to ptr_i so the nearest one wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible_i[(int'(ptr_i) + k) % NUM_REQ]) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/cdce_link_arbiter.sv
// Shares one CDCE serial write engine between NUM_REQ requesters with round-robin
// arbitration, an optional configuration lock, an inter-word gap and a transaction watchdog.
module cdce_link_arbiter
   import cdce_link_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CONFIG_LOCK    = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            config_done,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              ack,
   output logic [NUM_REQ-1:0]              err,
   output logic                            serial_start,
   output logic [DATA_WIDTH-1:0]           serial_data,
   input  logic                            serial_done,
   output logic                            busy,
   output logic [clog2(NUM_REQ)-1:0]       grant_id
);

   localparam int unsigned IdxW = clog2(NUM_REQ);
   localparam int unsigned ToW  = clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [ToW-1:0] ToLast  = ToW'(TIMEOUT_CYCLES - 2);
   localparam logic [ToW-1:0] ToMax   = '1;
   localparam logic [7:0]     GapLast = 8'(GAP_CYCLES);

   link_state_e           state_q, state_d;
   logic [IdxW-1:0]       grant_q, grant_d;
   logic [IdxW-1:0]       ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ToW-1:0]        to_cnt_q, to_cnt_d;
   logic [7:0]            gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic [NUM_REQ-1:0]    err_q, err_d;

   logic [NUM_REQ-1:0]    eligible;
   logic                  pick_valid;
   logic [IdxW-1:0]       pick_idx;
   logic [IdxW-1:0]       ptr_next;

   always_comb begin
      eligible = req;
      if ((CONFIG_LOCK != 0) && !config_done) begin
         eligible = req & NUM_REQ'(1);
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IdxW)
   ) u_rr_arbiter (
      .eligible_i (eligible),
      .ptr_i      (ptr_q),
      .valid_o    (pick_valid),
      .idx_o      (pick_idx)
   );

   assign ptr_next = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      data_d    = data_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      ack_d     = '0;
      err_d     = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               data_d  = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            to_cnt_d = '0;
            state_d  = StWait;
         end
         StWait: begin
            if (to_cnt_q != ToMax) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
            // Completion takes precedence over a watchdog expiring in the same cycle.
            if (serial_done) begin
               ack_d[grant_q] = 1'b1;
               ptr_d          = ptr_next;
               gap_cnt_d      = '0;
               state_d        = StGap;
            end else if (to_cnt_q >= ToLast) begin
               err_d[grant_q] = 1'b1;
               ptr_d          = ptr_next;
               gap_cnt_d      = '0;
               state_d        = StGap;
            end
         end
         StGap: begin
            if (gap_cnt_q >= GapLast) begin
               state_d = StIdle;
            end else if (gap_cnt_q != 8'hFF) begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         ptr_q     <= '0;
         data_q    <= '0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
         ack_q     <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign serial_start = (state_q == StLaunch);
   assign busy         = (state_q != StIdle);
   assign serial_data  = data_q;
   assign grant_id     = grant_q;
   assign ack          = ack_q;
   assign err          = err_q;

endmodule
